// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the 8N1 UART engine.
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int PHASE_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_if.sv
// Peripheral-side bundle of the UART core: serial lines plus byte-level tx/rx handshake.
interface uart_if;
  import uart_pkg::*;

  logic                 uart_rx;
  logic                 uart_tx;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_en;
  logic                 tx_status;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_status;

  modport master (output uart_rx, tx_data, tx_en,
                  input  uart_tx, tx_status, rx_data, rx_status);
  modport slave  (input  uart_rx, tx_data, tx_en,
                  output uart_tx, tx_status, rx_data, rx_status);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clk 16x-oversampling tick enable; no backpressure.
module uart_baud_tick #(
  parameter int CLKS_PER_TICK = 651
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_LAST);
endmodule

// File: rtl/uart_core.sv
// 8N1 UART: tick-paced TX/RX FSMs. TX accepts when idle and starts at the next tick;
// busy requests are dropped. RX reports each good byte with a one-clk rx_status pulse.
module uart_core #(
  parameter int CLKS_PER_TICK = 651
) (
  input  logic   clk,
  input  logic   reset,
  uart_if.slave  bus
);
  import uart_pkg::*;

  localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] PH_MID   = PHASE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic tick;

  uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  uart_state_e          tx_state, tx_state_n;
  logic [PHASE_W-1:0]   tx_phase, tx_phase_n;
  logic [BIT_W-1:0]     tx_bit,   tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_line,  tx_line_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_phase <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_phase <= tx_phase_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_phase_n = tx_phase;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    case (tx_state)
      IDLE: begin
        if (bus.tx_en) begin
          tx_state_n = START;
          tx_shift_n = bus.tx_data;
          tx_phase_n = '0;
        end
      end
      START: begin
        // line is still high on the first tick after accept: that tick opens the start bit
        if (tick) begin
          if (tx_line) begin
            tx_line_n = 1'b0;
          end else if (tx_phase == PH_LAST) begin
            tx_state_n = DATA;
            tx_phase_n = '0;
            tx_bit_n   = '0;
            tx_line_n  = tx_shift[0];
            tx_shift_n = tx_shift >> 1;
          end else begin
            tx_phase_n = tx_phase + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tx_phase == PH_LAST) begin
            tx_phase_n = '0;
            if (tx_bit == BIT_LAST) begin
              tx_state_n = STOP;
              tx_line_n  = 1'b1;
            end else begin
              tx_bit_n   = tx_bit + 1'b1;
              tx_line_n  = tx_shift[0];
              tx_shift_n = tx_shift >> 1;
            end
          end else begin
            tx_phase_n = tx_phase + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tx_phase == PH_LAST) tx_state_n = IDLE;
          else                     tx_phase_n = tx_phase + 1'b1;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  assign bus.uart_tx   = tx_line;
  assign bus.tx_status = (tx_state == IDLE);

  logic [1:0]           rx_sync;
  logic                 rx_prev;
  logic                 rx_s;
  uart_state_e          rx_state, rx_state_n;
  logic [PHASE_W-1:0]   rx_phase, rx_phase_n;
  logic [BIT_W-1:0]     rx_bit,   rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_brk,   rx_brk_n;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_n;
  logic                 rx_vld_q,  rx_vld_n;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync   <= 2'b11;
      rx_prev   <= 1'b1;
      rx_state  <= IDLE;
      rx_phase  <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_brk    <= 1'b0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], bus.uart_rx};
      rx_prev   <= rx_s;
      rx_state  <= rx_state_n;
      rx_phase  <= rx_phase_n;
      rx_bit    <= rx_bit_n;
      rx_shift  <= rx_shift_n;
      rx_brk    <= rx_brk_n;
      rx_data_q <= rx_data_n;
      rx_vld_q  <= rx_vld_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_phase_n = rx_phase;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_brk_n   = rx_brk;
    rx_data_n  = rx_data_q;
    rx_vld_n   = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_n = START;
          rx_phase_n = '0;
        end
      end
      START: begin
        if (tick) begin
          if (rx_phase == PH_MID) begin
            rx_phase_n = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_s ? IDLE : DATA;
          end else begin
            rx_phase_n = rx_phase + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (rx_phase == PH_LAST) begin
            rx_phase_n = '0;
            rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) begin
              rx_state_n = STOP;
              rx_brk_n   = 1'b0;
            end else begin
              rx_bit_n = rx_bit + 1'b1;
            end
          end else begin
            rx_phase_n = rx_phase + 1'b1;
          end
        end
      end
      STOP: begin
        // after a framing error, hold here until the line returns high
        if (rx_brk) begin
          if (rx_s) begin
            rx_brk_n   = 1'b0;
            rx_state_n = IDLE;
          end
        end else if (tick) begin
          if (rx_phase == PH_LAST) begin
            if (rx_s) begin
              rx_data_n  = rx_shift;
              rx_vld_n   = 1'b1;
              rx_state_n = IDLE;
            end else begin
              rx_brk_n = 1'b1;
            end
          end else begin
            rx_phase_n = rx_phase + 1'b1;
          end
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_status = rx_vld_q;
endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core with a 4-clk tick (64-clk bit, 640-clk frame).
module tb_uart_core;
  localparam int CPT = 4;
  localparam int BIT = 64;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic rx_drv  = 1'b1;
  logic loop_en = 1'b0;

  always #5 clk = ~clk;

  uart_if u_if();
  assign u_if.uart_rx = loop_en ? u_if.uart_tx : rx_drv;

  uart_core #(.CLKS_PER_TICK(CPT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  int vectors     = 0;
  int miscompares = 0;
  int rx_pulses   = 0;

  always @(negedge clk) if (u_if.rx_status === 1'b1) rx_pulses <= rx_pulses + 1;

  task automatic capture_tx(input int max_wait, output logic [9:0] bits, output int waited,
                            output bit seen);
    waited = 0;
    seen   = 1'b0;
    bits   = '1;
    while (u_if.uart_tx !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    if (u_if.uart_tx === 1'b0) begin
      seen = 1'b1;
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        bits[i] = u_if.uart_tx;
        if (i < 9) repeat (BIT) @(negedge clk);
      end
    end
  endtask

  task automatic wait_tx_idle(input int limit, output int n);
    n = 0;
    while (u_if.tx_status !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int bclk);
    rx_drv = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bclk) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (bclk) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (u_if.uart_tx !== 1'b1) begin
      miscompares++; $display("FAIL reset_uart_tx: got %b want 1", u_if.uart_tx);
    end
    vectors++;
    if (u_if.tx_status !== 1'b1) begin
      miscompares++; $display("FAIL reset_tx_status: got %b want 1", u_if.tx_status);
    end
    vectors++;
    if (u_if.rx_status !== 1'b0) begin
      miscompares++; $display("FAIL reset_rx_status: got %b want 0", u_if.rx_status);
    end
    vectors++;
    if (u_if.rx_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_rx_data: got %h want 00", u_if.rx_data);
    end
    reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_tx_a5;
    logic [9:0] f;
    logic [9:0] exp_seq;
    int w, n;
    bit s;
    exp_seq = 10'b1101001010;
    u_if.tx_data = 8'hA5;
    u_if.tx_en   = 1'b1;
    @(negedge clk);
    u_if.tx_en   = 1'b0;
    vectors++;
    if (u_if.tx_status !== 1'b0) begin
      miscompares++; $display("FAIL tx_accept_status: got %b want 0", u_if.tx_status);
    end
    capture_tx(CPT + 2, f, w, s);
    vectors++;
    if (!s || w > CPT) begin
      miscompares++; $display("FAIL tx_start_delay: got %0d clk (seen=%0d) want <= %0d", w, s, CPT);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (f[i] !== exp_seq[i]) begin
        miscompares++; $display("FAIL tx_a5_bit%0d: got %b want %b", i, f[i], exp_seq[i]);
      end
    end
    wait_tx_idle(200, n);
    vectors++;
    if (u_if.tx_status !== 1'b1 || n < 31 || n > 33) begin
      miscompares++;
      $display("FAIL tx_done_status: got %b after %0d clk want 1 after 31..33", u_if.tx_status, n);
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_tx_busy;
    logic [9:0] f;
    int w, n, lows;
    bit s;
    u_if.tx_data = 8'h96;
    u_if.tx_en   = 1'b1;
    @(negedge clk);
    u_if.tx_en   = 1'b0;
    fork
      capture_tx(CPT + 2, f, w, s);
      begin
        repeat (300) @(negedge clk);
        u_if.tx_data = 8'h3C;
        u_if.tx_en   = 1'b1;
        @(negedge clk);
        u_if.tx_en   = 1'b0;
      end
    join
    vectors++;
    if (!s || f !== {1'b1, 8'h96, 1'b0}) begin
      miscompares++; $display("FAIL tx_busy_frame: got %b want %b", f, {1'b1, 8'h96, 1'b0});
    end
    wait_tx_idle(200, n);
    lows = 0;
    repeat (128) begin
      @(negedge clk);
      if (u_if.uart_tx !== 1'b1) lows++;
    end
    vectors++;
    if (lows != 0 || u_if.tx_status !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_busy_ignored: got %0d low clk status %b want 0 low status 1", lows, u_if.tx_status);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] f1, f2;
    int w1, w2, n, lows;
    bit s1, s2;
    u_if.tx_data = 8'h55;
    u_if.tx_en   = 1'b1;
    fork
      begin
        capture_tx(CPT + 4, f1, w1, s1);
        capture_tx(80, f2, w2, s2);
      end
      begin
        repeat (700) @(negedge clk);
        u_if.tx_en = 1'b0;
      end
    join
    vectors++;
    if (!s1 || f1 !== {1'b1, 8'h55, 1'b0}) begin
      miscompares++; $display("FAIL b2b_frame1: got %b want %b", f1, {1'b1, 8'h55, 1'b0});
    end
    vectors++;
    if (!s2 || f2 !== {1'b1, 8'h55, 1'b0}) begin
      miscompares++; $display("FAIL b2b_frame2: got %b want %b", f2, {1'b1, 8'h55, 1'b0});
    end
    vectors++;
    if (!s2 || w2 > 40) begin
      miscompares++; $display("FAIL b2b_gap: got %0d clk from stop centre want <= 40", w2);
    end
    wait_tx_idle(200, n);
    lows = 0;
    repeat (128) begin
      @(negedge clk);
      if (u_if.uart_tx !== 1'b1) lows++;
    end
    vectors++;
    if (lows != 0) begin
      miscompares++; $display("FAIL b2b_no_third: got %0d low clk want 0", lows);
    end
  endtask

  task automatic test_reset_mid_tx;
    u_if.tx_data = 8'h00;
    u_if.tx_en   = 1'b1;
    @(negedge clk);
    u_if.tx_en   = 1'b0;
    repeat (200) @(negedge clk);
    vectors++;
    if (u_if.uart_tx !== 1'b0) begin
      miscompares++; $display("FAIL midreset_pre_line: got %b want 0", u_if.uart_tx);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (u_if.uart_tx !== 1'b1) begin
      miscompares++; $display("FAIL midreset_uart_tx: got %b want 1", u_if.uart_tx);
    end
    vectors++;
    if (u_if.tx_status !== 1'b1) begin
      miscompares++; $display("FAIL midreset_tx_status: got %b want 1", u_if.tx_status);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_rx_nominal;
    int p;
    logic [7:0] bytes [2];
    int clks [2];
    bytes = '{8'h96, 8'h2D};
    clks  = '{66, 62};
    p = rx_pulses;
    send_rx(8'hC3, 1'b1, BIT);
    repeat (20) @(negedge clk);
    vectors++;
    if (rx_pulses - p != 1) begin
      miscompares++; $display("FAIL rx_c3_pulse: got %0d pulse clk want 1", rx_pulses - p);
    end
    vectors++;
    if (u_if.rx_data !== 8'hC3) begin
      miscompares++; $display("FAIL rx_c3_data: got %h want c3", u_if.rx_data);
    end
    for (int k = 0; k < 2; k++) begin
      p = rx_pulses;
      send_rx(bytes[k], 1'b1, clks[k]);
      repeat (20) @(negedge clk);
      vectors++;
      if (rx_pulses - p != 1 || u_if.rx_data !== bytes[k]) begin
        miscompares++;
        $display("FAIL rx_skew_%0dclk: got %h (%0d pulses) want %h (1 pulse)",
                 clks[k], u_if.rx_data, rx_pulses - p, bytes[k]);
      end
    end
  endtask

  task automatic test_rx_glitch;
    int p;
    p = rx_pulses;
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    vectors++;
    if (rx_pulses - p != 0) begin
      miscompares++; $display("FAIL rx_glitch_pulse: got %0d want 0", rx_pulses - p);
    end
    p = rx_pulses;
    send_rx(8'hE7, 1'b1, BIT);
    repeat (20) @(negedge clk);
    vectors++;
    if (rx_pulses - p != 1 || u_if.rx_data !== 8'hE7) begin
      miscompares++;
      $display("FAIL rx_after_glitch: got %h (%0d pulses) want e7 (1 pulse)", u_if.rx_data, rx_pulses - p);
    end
  endtask

  task automatic test_rx_framing;
    int p;
    p = rx_pulses;
    send_rx(8'h81, 1'b0, BIT);
    repeat (40) @(negedge clk);
    vectors++;
    if (rx_pulses - p != 0) begin
      miscompares++; $display("FAIL rx_ferr_pulse: got %0d want 0", rx_pulses - p);
    end
    vectors++;
    if (u_if.rx_data !== 8'hE7) begin
      miscompares++; $display("FAIL rx_ferr_data_held: got %h want e7", u_if.rx_data);
    end
    p = rx_pulses;
    send_rx(8'h7E, 1'b1, BIT);
    repeat (20) @(negedge clk);
    vectors++;
    if (rx_pulses - p != 1 || u_if.rx_data !== 8'h7E) begin
      miscompares++;
      $display("FAIL rx_after_ferr: got %h (%0d pulses) want 7e (1 pulse)", u_if.rx_data, rx_pulses - p);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] bytes [3];
    int p, n;
    bytes = '{8'h00, 8'hFF, 8'h5A};
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      p = rx_pulses;
      u_if.tx_data = bytes[k];
      u_if.tx_en   = 1'b1;
      @(negedge clk);
      u_if.tx_en   = 1'b0;
      wait_tx_idle(1000, n);
      repeat (20) @(negedge clk);
      vectors++;
      if (u_if.tx_status !== 1'b1 || rx_pulses - p != 1 || u_if.rx_data !== bytes[k]) begin
        miscompares++;
        $display("FAIL loopback_%h: got %h (%0d pulses, tx_status %b) want %h (1 pulse, 1)",
                 bytes[k], u_if.rx_data, rx_pulses - p, u_if.tx_status, bytes[k]);
      end
    end
    loop_en = 1'b0;
  endtask

  initial begin
    u_if.tx_data = 8'h00;
    u_if.tx_en   = 1'b0;
    @(negedge clk);
    test_reset();
    test_tx_a5();
    test_tx_busy();
    test_back_to_back();
    test_reset_mid_tx();
    test_rx_nominal();
    test_rx_glitch();
    test_rx_framing();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
